while_ent_inv: RTL and testbench
================================

Name: while_ent_inv

Overview:
- Inverse (decoder) of the WhileEnt affine encoder `XOUT = (M*A) mod 2^W - B`, with `M = COUNT+1`.
- Takes an encoded `XOUT` and its key `B`, and recovers `A` with a bit-serial modular solve, one bit per clock.
- Sits downstream of WhileEnt instances in the pipeline.
- Uses valid/ready handshakes on both sides.

Parameters:
- W, 8, datapath width in bits for `XOUT`, `B` and `A`.
- COUNT, 4, loop count of the matching encoder; the multiplier is `M = COUNT+1`. COUNT must be even so that M is odd and invertible mod 2^W. An odd COUNT raises an elaboration `$error`.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  `XOUT`/`B` pair valid.
- IN_READY  output  1  block can accept a pair.
- XOUT  input  W  encoded value.
- B  input  W  encoder subtrahend.
- OUT_VALID  output  1  result `A` valid.
- OUT_READY  input  1  consumer accepts `A`.
- A  output  W  recovered operand.
- BUSY  output  1  high in SOLVE.

Behaviour:
- One clock (CLK); reset RST_N is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - OUT_VALID = 0, A = 0, BUSY = 0
  - internal residue r = 0, index i = 0, accumulator acc = 0
  - IN_READY = 1 once reset is released
- States: IDLE, SOLVE, DONE.
- IDLE:
  - IN_READY = 1.
  - On IN_VALID: load r <= (XOUT + B) mod 2^W, i <= 0, acc <= 0, go to SOLVE.
- SOLVE (exactly W cycles):
  - IN_READY = 0, BUSY = 1.
  - Each cycle: acc[i] <= r[i]; if r[i] = 1, r <= (r - (M << i)) mod 2^W; i <= i + 1.
  - When i = W-1: go to DONE.
- DONE:
  - OUT_VALID = 1, A = acc.
  - A is held stable while OUT_READY = 0.
  - On OUT_READY: OUT_VALID <= 0, go to IDLE.
- Latency: pair accepted at edge k → OUT_VALID high after edge k+W. For W=8, 8 cycles accept-to-valid.
- Throughput without the optional feature: one result per W+2 cycles.
- Arithmetic: all sums and differences truncate to W bits. `M << i` is truncated to W bits.
- Correctness invariant: `(M*A - B) mod 2^W == XOUT` for every result.
- Boundaries:
  - IN_VALID while not IN_READY is ignored; the source must hold the pair.
  - OUT_READY high outside DONE has no effect.
  - XOUT + B overflow wraps.
  - COUNT = 0 (M = 1) gives A = XOUT + B.
  - RST_N asserted mid-SOLVE or mid-DONE aborts immediately: OUT_VALID drops asynchronously and the partial result is discarded.

Optional Feature:
- Macro: `WHILE_ENT_INV_BACK2BACK_EN`.
- Defined:
  - In DONE, IN_READY = OUT_READY (combinational).
  - If OUT_VALID && OUT_READY && IN_VALID in the same cycle, the new pair loads and the state goes DONE → SOLVE directly, skipping IDLE.
  - Throughput becomes one result per W+1 cycles.
- Undefined:
  - IN_READY is high only in IDLE; DONE always returns to IDLE first.

Test Plan:
- W=8, COUNT=4: XOUT=8, B=7 → A=3 (r=15; bit0 → r=10; bit1 → r=0). OUT_VALID rises 8 cycles after accept.
- XOUT=222, B=10 → A=200. XOUT=255, B=1 → A=0 (wrap of XOUT+B to 0).
- Random sweep, 1000 pairs: encode a random A,B via the WhileEnt model, feed XOUT,B → recovered A equals the original every time. IN_READY is low throughout SOLVE/DONE.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE → A stable, OUT_VALID stays 1, IN_VALID ignored. Release → one handshake, then return to IDLE.
- Reset at SOLVE cycle 4 → OUT_VALID=0, A=0, IN_READY=1 after release. Next pair XOUT=8, B=7 → A=3 with no residue corruption.
- With `WHILE_ENT_INV_BACK2BACK_EN`: continuous IN_VALID and OUT_READY=1 → results spaced 9 cycles apart (W+1). Without the macro: spaced 10 cycles apart.

Source files
------------

// File: rtl/while_ent_inv.sv
// while_ent_inv: bit-serial decoder for the WhileEnt affine encoder
//   xout = (M*a) mod 2^W - b, with M = COUNT+1 (odd, so invertible mod 2^W).
// Recovers a one bit per clock: IDLE -> SOLVE (W cycles) -> DONE.
// Optional macro WHILE_ENT_INV_BACK2BACK_EN lets DONE hand off straight to
// SOLVE when a new pair is waiting as the result is consumed.
module while_ent_inv #(
  parameter int unsigned W     = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] xout,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a,
  output logic         busy
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MW = W'(COUNT + 1);

  // An even multiplier has no inverse mod 2^W, so refuse to elaborate.
  if ((COUNT % 2) != 0) begin : g_count_check
    $error("while_ent_inv: COUNT must be even so that M = COUNT+1 is odd");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOLVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   r, r_n;
  logic [IW-1:0]  i, i_n;
  logic [W-1:0]   acc, acc_n;
  logic [W-1:0]   a_n;
  logic           out_valid_n;
  logic           busy_n;

  // Accept decode: idle always, or DONE while the consumer takes the result.
`ifdef WHILE_ENT_INV_BACK2BACK_EN
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
`else
  assign in_ready = (state == IDLE);
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '0;
      i         <= '0;
      acc       <= '0;
      a         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      i         <= i_n;
      acc       <= acc_n;
      a         <= a_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
    end
  end

  // Next-state and datapath: peel one bit of a per SOLVE cycle. Since M is
  // odd, bit i of the residue equals bit i of the remaining quotient.
  always_comb begin
    state_n     = state;
    r_n         = r;
    i_n         = i;
    acc_n       = acc;
    a_n         = a;
    out_valid_n = out_valid;
    busy_n      = busy;
    case (state)
      IDLE: begin
        if (in_valid) begin
          r_n     = xout + b;
          i_n     = '0;
          acc_n   = '0;
          busy_n  = 1'b1;
          state_n = SOLVE;
        end
      end
      SOLVE: begin
        acc_n[i] = r[i];
        if (r[i]) begin
          r_n = r - (MW << i);
        end
        i_n = i + IW'(1);
        if (i == IW'(W - 1)) begin
          a_n         = acc_n;
          out_valid_n = 1'b1;
          busy_n      = 1'b0;
          state_n     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
`ifdef WHILE_ENT_INV_BACK2BACK_EN
          if (in_valid) begin
            r_n     = xout + b;
            i_n     = '0;
            acc_n   = '0;
            busy_n  = 1'b1;
            state_n = SOLVE;
          end
`endif
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_while_ent_inv.sv
// tb_while_ent_inv: directed plus randomized checks of while_ent_inv against
// an arithmetic model of the WhileEnt encoder.
module tb_while_ent_inv;

  localparam int unsigned W     = 8;
  localparam int unsigned COUNT = 4;
  localparam int unsigned M     = COUNT + 1;
`ifdef WHILE_ENT_INV_BACK2BACK_EN
  localparam int PERIOD = W + 1;
`else
  localparam int PERIOD = W + 2;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] xout;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  while_ent_inv #(.W(W), .COUNT(COUNT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xout      (xout),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Encoder model: xout = (M*a - b) mod 2^W.
  function automatic logic [W-1:0] encode(input int av, input int bv);
    int v;
    v = (int'(M) * av - bv) % (1 << W);
    if (v < 0) v += (1 << W);
    return W'(v);
  endfunction

  // Decoder model: search for the unique a that encodes to xout.
  function automatic int decode(input int xv, input int bv);
    for (int c = 0; c < (1 << W); c++) begin
      if (int'(encode(c, bv)) == xv) return c;
    end
    return -1;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_rdy"}, int'(in_ready), 1);
  endtask

  // Push one pair, check latency/flags/result, then hold off the consumer
  // for 'hold' cycles before handshaking.
  task automatic run_pair(input logic [W-1:0] xv, input logic [W-1:0] bv,
                          input int exp, input int hold, input string tag);
    int  cyc = 0;
    bit  flags_ok = 1'b1;
    logic [W-1:0] held;
    wait_ready(tag);
    xout = xv; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    xout = $urandom; b = $urandom;
    while (!out_valid && cyc < W + 4) begin
      if (!busy || in_ready) flags_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, W);
    check({tag, "_flags"}, int'(flags_ok), 1);
    check({tag, "_a"}, int'(a), exp);
    held = a;
    if (hold > 0) begin
      in_valid = 1'b1;
      flags_ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || a != held) flags_ok = 1'b0;
      end
      in_valid = 1'b0;
      check({tag, "_hold"}, int'(flags_ok), 1);
      check({tag, "_hold_a"}, int'(a), exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovdrop"}, int'(out_valid), 0);
    check({tag, "_idle"}, int'(in_ready), 1);
  endtask

  initial begin
    int t[3];
    int nev;
    int n;
    int av;
    int bv;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; xout = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", int'(out_valid), 0);
    check("rst_a", int'(a), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", int'(in_ready), 1);

    // out_ready outside DONE does nothing
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ordy_ov", int'(out_valid), 0);
    check("idle_ordy_busy", int'(busy), 0);
    out_ready = 1'b0;

    // Directed vectors
    run_pair(8'd8,   8'd7,  3,   0, "d0");
    run_pair(8'd222, 8'd10, 200, 0, "d1");
    run_pair(8'd255, 8'd1,  0,   0, "d2");
    check("model_d1", decode(222, 10), 200);

    // Backpressure: 5 cycles of out_ready low with in_valid asserted
    run_pair(8'd8, 8'd7, 3, 5, "bp");

    // Random sweep through the encoder model
    for (int k = 0; k < 1000; k++) begin
      av = int'($urandom_range(0, (1 << W) - 1));
      bv = int'($urandom_range(0, (1 << W) - 1));
      run_pair(encode(av, bv), W'(bv), av, int'($urandom_range(0, 2)), "rnd");
    end

    // Throughput with continuous traffic
    wait_ready("tp");
    xout = 8'd8; b = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
    nev = 0; n = 0;
    while (nev < 3 && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) begin
        t[nev] = n;
        check("tp_a", int'(a), 3);
        nev++;
      end
    end
    in_valid = 1'b0;
    check("tp_events", nev, 3);
    if (nev == 3) begin
      check("tp_gap0", t[1] - t[0], PERIOD);
      check("tp_gap1", t[2] - t[1], PERIOD);
    end
    n = 0;
    while ((out_valid || busy || !in_ready) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    check("tp_drain", int'(in_ready), 1);

    // Reset during SOLVE discards the partial result
    xout = 8'd222; b = 8'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", int'(out_valid), 0);
    check("mid_rst_a", int'(a), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rdy", int'(in_ready), 1);
    run_pair(8'd8, 8'd7, 3, 0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
